// File: rtl/aes_inv_cipher_seq_pkg.sv
// Shared AES-256 inverse-cipher constants, state encodings and the inverse-round
// byte functions (InvShiftRows, InvSubBytes, InvMixColumns) used by the round datapath.
package aes_inv_cipher_seq_pkg;

  localparam int AES_NR_256 = 14;
  localparam int AES_BLK_W  = 128;
  localparam int AES_KIDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } seqState_e;

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prod;
    logic [7:0] acc;
    prod = '0;
    acc  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ acc;
      acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
    end
    return prod;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero naturally.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] res;
    logic [7:0] base;
    res  = 8'h01;
    base = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) res = gfMul(res, base);
      base = gfMul(base, base);
    end
    return res;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gfInv(t);
  endfunction

  function automatic logic [AES_BLK_W-1:0] invShiftRows(input logic [AES_BLK_W-1:0] blk);
    logic [AES_BLK_W-1:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[8*(15-(r+4*c)) +: 8] = blk[8*(15-(r+4*((c-r+4)%4))) +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [AES_BLK_W-1:0] invSubBytes(input logic [AES_BLK_W-1:0] blk);
    logic [AES_BLK_W-1:0] res;
    res = '0;
    for (int k = 0; k < 16; k++) res[8*k +: 8] = invSbox(blk[8*k +: 8]);
    return res;
  endfunction

  function automatic logic [AES_BLK_W-1:0] invMixColumns(input logic [AES_BLK_W-1:0] blk);
    logic [AES_BLK_W-1:0] res;
    logic [7:0] a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = blk[8*(15-4*c) +: 8];
      a1 = blk[8*(14-4*c) +: 8];
      a2 = blk[8*(13-4*c) +: 8];
      a3 = blk[8*(12-4*c) +: 8];
      res[8*(15-4*c) +: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
      res[8*(14-4*c) +: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
      res[8*(13-4*c) +: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
      res[8*(12-4*c) +: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_seq_round_dp.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round_dp
  import aes_inv_cipher_seq_pkg::*;
(
  input  logic [AES_BLK_W-1:0] state,
  input  logic [AES_BLK_W-1:0] roundKey,
  input  logic                 isFinal,
  output logic [AES_BLK_W-1:0] nextState
);

  logic [AES_BLK_W-1:0] keyed;

  always_comb begin
    keyed     = invSubBytes(invShiftRows(state)) ^ roundKey;
    nextState = isFinal ? keyed : invMixColumns(keyed);
  end

endmodule

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES-256 inverse-cipher sequencer: one inverse round per clock over a
// shared datapath, round keys fetched by index from an external key store.
module aes_inv_cipher_seq
  import aes_inv_cipher_seq_pkg::*;
#(
  parameter int NR     = AES_NR_256,
  parameter int KIDX_W = AES_KIDX_W
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 flush,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [AES_BLK_W-1:0] inData,
  output logic [KIDX_W-1:0]    roundKeyIdx,
  input  logic [AES_BLK_W-1:0] roundKey,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [AES_BLK_W-1:0] outData,
  output logic                 busy
);

  seqState_e            stateQ, stateD;
  logic [KIDX_W-1:0]    cntQ, cntD;
  logic [AES_BLK_W-1:0] dataQ, dataD;
  logic [AES_BLK_W-1:0] dpNext;
  logic                 isFinal;

  assign isFinal = (stateQ == FINAL);

  aes_inv_round_dp uRoundDp (
    .state     (dataQ),
    .roundKey  (roundKey),
    .isFinal   (isFinal),
    .nextState (dpNext)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ <= IDLE;
      cntQ   <= KIDX_W'(NR - 1);
      dataQ  <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      dataQ  <= dataD;
    end
  end

  // Counter only decrements in ROUND and holds at 1 through FINAL/DONE.
  always_comb begin
    stateD      = stateQ;
    cntD        = cntQ;
    dataD       = dataQ;
    roundKeyIdx = KIDX_W'(NR);
    unique case (stateQ)
      IDLE: begin
        if (inValid) begin
          dataD  = inData ^ roundKey;
          cntD   = KIDX_W'(NR - 1);
          stateD = ROUND;
        end
      end
      ROUND: begin
        roundKeyIdx = cntQ;
        dataD       = dpNext;
        if (cntQ == KIDX_W'(1)) stateD = FINAL;
        else cntD = cntQ - KIDX_W'(1);
      end
      FINAL: begin
        roundKeyIdx = '0;
        dataD       = dpNext;
        stateD      = DONE;
      end
      DONE: begin
        roundKeyIdx = '0;
        if (outReady) stateD = IDLE;
      end
      default: ;
    endcase
    if (flush) begin
      stateD = IDLE;
      cntD   = KIDX_W'(NR - 1);
      dataD  = dataQ;
    end
  end

  assign inReady  = (stateQ == IDLE);
  assign outValid = (stateQ == DONE);
  assign busy     = (stateQ != IDLE);
  assign outData  = dataQ;

endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// Self-checking bench for aes_inv_cipher_seq: key-store model, forward AES-256 reference
// built from first principles, and a plaintext scoreboard fed at accept time.
module tb_aes_inv_cipher_seq;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam int NBLK = 1000;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         flush = 1'b0;
  logic         inValid = 1'b0;
  logic         outReady = 1'b0;
  logic [127:0] inData = '0;
  logic         inReady, outValid, busy;
  logic [3:0]   roundKeyIdx;
  logic [127:0] roundKey, outData;

  logic [127:0] keyMem [0:15];
  logic [7:0]   sbox [0:255];
  logic [127:0] expQ [$];
  logic [127:0] curExp = '0;
  int           checks = 0;
  int           errors = 0;
  int           cycle = 0;
  int           outCount = 0;

  assign roundKey = keyMem[roundKeyIdx];

  aes_inv_cipher_seq dut (
    .clk         (clk),
    .rstN        (rstN),
    .flush       (flush),
    .inValid     (inValid),
    .inReady     (inReady),
    .inData      (inData),
    .roundKeyIdx (roundKeyIdx),
    .roundKey    (roundKey),
    .outValid    (outValid),
    .outReady    (outReady),
    .outData     (outData),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = b;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // Forward S-box from its definition: brute-force inverse, then the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expandKey(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    assert (busy === 1'b0) else $error("[TB] key store rewritten while busy");
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) keyMem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    keyMem[15] = '0;
  endtask

  function automatic logic [127:0] aesEncrypt(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0] a0, a1, a2, a3;
    s = pt ^ keyMem[0];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox[s[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      s = t;
      if (rnd != 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8]; a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
          s[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      s = s ^ keyMem[rnd];
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] exp, output int acceptAt);
    logic wasReady;
    acceptAt = -1;
    inData   = ct;
    curExp   = exp;
    inValid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wasReady = inReady;
      tick();
      if (wasReady) begin
        acceptAt = cycle;
        break;
      end
    end
    if (acceptAt < 0) checkOutput("acceptTimeout", 128'(inReady), 128'd1);
  endtask

  task automatic waitOutValid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (outValid) return;
      tick();
    end
    checkOutput("outValidTimeout", 128'(outValid), 128'd1);
  endtask

  task automatic waitIdx(input logic [3:0] idx, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (roundKeyIdx == idx) return;
      tick();
    end
    checkOutput("roundIdxTimeout", 128'(roundKeyIdx), 128'(idx));
  endtask

  // Scoreboard: push at accept, pop at output handshake, drop on flush/reset.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstN) begin
        expQ.delete();
      end else if (flush) begin
        if (busy && expQ.size() > 0) void'(expQ.pop_front());
      end else begin
        if (outValid && outReady) begin
          if (expQ.size() == 0) checkOutput("spuriousOut", 128'(outValid), 128'd0);
          else begin
            checkOutput("plaintext", outData, expQ.pop_front());
            outCount++;
          end
        end
        if (inValid && inReady) expQ.push_back(curExp);
      end
    end
  end

  initial begin
    int a0, a1;
    int sent;
    int startCnt;
    logic wasReady;
    logic [127:0] pt, pt2, ct2, pt3, ct3;

    buildSbox();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expandKey(FIPS_KEY);
    checkOutput("resetCtl", 128'({inReady, outValid, busy, roundKeyIdx}), 128'({3'b100, 4'd14}));
    checkOutput("resetData", outData, 128'd0);
    rstN = 1'b1;
    tick();

    pt2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    ct2 = aesEncrypt(pt2);
    pt3 = 128'hdeadbeef0123456789abcdeffedcba98;
    ct3 = aesEncrypt(pt3);

    // FIPS-197 C.3 vector with latency and key-index sequence.
    outReady = 1'b1;
    applyStimulus(FIPS_CT, FIPS_PT, a0);
    inValid = 1'b0;
    for (int e = 0; e < 14; e++) begin
      checkOutput("rkIdx", 128'(roundKeyIdx), (e <= 12) ? 128'(13 - e) : 128'd0);
      checkOutput("noEarlyValid", 128'(outValid), 128'd0);
      tick();
    end
    checkOutput("latency14", 128'(outValid), 128'd1);
    tick();
    checkOutput("idleAfterOut", 128'({inReady, outValid, busy}), 128'(3'b100));

    // Backpressure: output held for 20 cycles.
    outReady = 1'b0;
    applyStimulus(FIPS_CT, FIPS_PT, a0);
    inValid = 1'b0;
    waitOutValid(40);
    for (int i = 0; i < 20; i++) begin
      checkOutput("bpHold", 128'({outValid, inReady}), 128'(2'b10));
      checkOutput("bpData", outData, FIPS_PT);
      tick();
    end
    outReady = 1'b1;
    tick();
    checkOutput("bpRelease", 128'({inReady, outValid, busy}), 128'(3'b100));

    // Back-to-back with inValid held high.
    applyStimulus(FIPS_CT, FIPS_PT, a0);
    applyStimulus(ct2, pt2, a1);
    inValid = 1'b0;
    checkOutput("b2bSpacing", 128'(a1 - a0), 128'd16);
    waitOutValid(30);
    tick();

    // Asynchronous reset at round 7.
    applyStimulus(ct3, pt3, a0);
    inValid = 1'b0;
    waitIdx(4'd7, 30);
    rstN = 1'b0;
    #1;
    checkOutput("midResetCtl", 128'({inReady, outValid, busy, roundKeyIdx}), 128'({3'b100, 4'd14}));
    checkOutput("midResetData", outData, 128'd0);
    @(negedge clk);
    tick();
    rstN = 1'b1;
    tick();
    applyStimulus(ct3, pt3, a0);
    inValid = 1'b0;
    waitOutValid(30);
    tick();

    // Flush in ROUND at counter 5, then in DONE.
    applyStimulus(ct2, pt2, a0);
    inValid = 1'b0;
    waitIdx(4'd5, 30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushRound", 128'({inReady, outValid, busy, roundKeyIdx}), 128'({3'b100, 4'd14}));
    repeat (20) tick();
    outReady = 1'b0;
    applyStimulus(FIPS_CT, FIPS_PT, a0);
    inValid = 1'b0;
    waitOutValid(30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushDone", 128'({inReady, outValid, busy}), 128'(3'b100));
    checkOutput("flushKeepsData", outData, FIPS_PT);
    outReady = 1'b1;
    applyStimulus(ct2, pt2, a0);
    inValid = 1'b0;
    waitOutValid(30);
    tick();

    // inValid pulse while busy must be ignored.
    applyStimulus(ct3, pt3, a0);
    inValid = 1'b0;
    repeat (3) tick();
    inData  = ct2;
    curExp  = pt2;
    inValid = 1'b1;
    checkOutput("busyNotReady", 128'({inReady, busy}), 128'(2'b01));
    tick();
    inValid = 1'b0;
    checkOutput("busyIgnoreIdx", 128'(roundKeyIdx), 128'd9);
    waitOutValid(30);
    tick();
    tick();

    // Random regression with a fresh key and random output stalls.
    expandKey({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    sent = 0;
    startCnt = outCount;
    for (int cyc = 0; cyc < 60000 && (outCount - startCnt) < NBLK; cyc++) begin
      if (!inValid && sent < NBLK && $urandom_range(0, 3) != 0) begin
        pt      = {$urandom, $urandom, $urandom, $urandom};
        inData  = aesEncrypt(pt);
        curExp  = pt;
        inValid = 1'b1;
      end
      outReady = ($urandom_range(0, 3) != 0);
      wasReady = inReady;
      tick();
      if (inValid && wasReady) begin
        sent++;
        inValid = 1'b0;
      end
    end
    outReady = 1'b1;
    checkOutput("regressCount", 128'(outCount - startCnt), 128'(NBLK));
    checkOutput("scoreboardEmpty", 128'(expQ.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
